alu_issue_sequencer: RTL and testbench

Buffers 19-bit ALU instructions from an upstream producer and issues them one at a time to the existing combinational CU. It registers each result and presents it downstream with a valid/ready handshake. It sits between the instruction source and the result consumer, giving the CU a registered, back-pressured pipeline stage. It also keeps an operation counter and a sticky illegal-opcode flag for debug.

---
 rtl/alu_issue_sequencer_pkg.sv | 28 ++
 rtl/alu_issue_sequencer_cu.sv | 33 +++
 rtl/alu_issue_sequencer_instr_fifo.sv | 79 +++++++
 rtl/alu_issue_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_issue_sequencer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_sequencer_pkg.sv
// rtl/alu_issue_sequencer_pkg.sv - shared opcodes, instruction field positions and FSM states
package alu_issue_sequencer_pkg;

    localparam int INSTR_W = 19;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_INC = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    localparam int OPC_MSB = 18;
    localparam int OPC_LSB = 16;
    localparam int A_MSB   = 15;
    localparam int A_LSB   = 8;
    localparam int B_MSB   = 7;
    localparam int B_LSB   = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STALL = 2'b10
    } seq_state_e;

endpackage

// File: rtl/alu_issue_sequencer_cu.sv
// rtl/alu_issue_sequencer_cu.sv - combinational 8-bit ALU control unit
// Ports: result (8-bit ALU output), instruction ([18:16] opcode, [15:8] A, [7:0] B).
// Opcode 000 is not an operation and yields 0.
module cu
    import alu_issue_sequencer_pkg::*;
(
    output logic [7:0]         result,
    input  logic [INSTR_W-1:0] instruction
);

    logic [2:0] opc;
    logic [7:0] a;
    logic [7:0] b;

    assign opc = instruction[OPC_MSB:OPC_LSB];
    assign a   = instruction[A_MSB:A_LSB];
    assign b   = instruction[B_MSB:B_LSB];

    always_comb begin
        result = 8'h00;
        case (opc)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_INC:  result = a + 8'd1;
            OP_DEC:  result = a - 8'd1;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~a;
            default: result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_issue_sequencer_instr_fifo.sv
// rtl/alu_issue_sequencer_instr_fifo.sv - DEPTH x WIDTH instruction FIFO with count
// Ports: clk, rst_n (async active-low), clr_i (sync clear, dominates push/pop),
//        push_i/wr_data_i, pop_i/rd_data_o (head, valid when !empty_o),
//        full_o, empty_o, count_o (entries held, 0..DEPTH).
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o    = (count_q == CNT_FULL);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Guards keep the FIFO self-consistent even if a caller ignores full/empty.
    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/alu_issue_sequencer.sv
// rtl/alu_issue_sequencer.sv - buffered, back-pressured issue stage around the ALU CU
// Ports: clk, rst_n (async active-low);
//        in_valid/in_ready/in_instr  upstream instruction handshake;
//        out_valid/out_ready         downstream result handshake, out_result/out_opcode payload;
//        flush                       sync clear of FIFO and output register;
//        busy, err_illegal (sticky), op_count (accepted results, wraps).
module alu_issue_sequencer
    import alu_issue_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_result,
    output logic [2:0]         out_opcode,
    output logic               busy,
    output logic               err_illegal,
    output logic [CNT_W-1:0]   op_count
);

    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] OPS_ONE = CNT_W'(1);

    seq_state_e         state_q, state_d;
    logic [7:0]         result_q, result_d;
    logic [2:0]         opcode_q, opcode_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic [FCNT_W-1:0]  fifo_count;
    logic [7:0]         cu_result;

    logic               push;
    logic               issue;
    logic               head_illegal;
    logic               load;
    logic               handshake;
    logic               valid_next;

    // out_valid is a property of the FSM: any non-IDLE state holds a result.
    assign out_valid   = (state_q != S_IDLE);
    assign out_result  = result_q;
    assign out_opcode  = opcode_q;
    assign err_illegal = err_q;
    assign op_count    = count_q;
    assign in_ready    = !fifo_full;
    assign busy        = (fifo_count != '0) || out_valid;

    assign push         = in_valid && !fifo_full && !flush;
    assign issue        = !fifo_empty && (!out_valid || out_ready) && !flush;
    assign head_illegal = (fifo_head[OPC_MSB:OPC_LSB] == OP_NOP);
    assign load         = issue && !head_illegal;
    assign handshake    = out_valid && out_ready;
    // An illegal pop produces nothing, so the output is valid afterwards only
    // if a legal result loads or the current one is held by back-pressure.
    assign valid_next   = load || (out_valid && !out_ready);

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (flush),
        .push_i    (push),
        .wr_data_i (in_instr),
        .pop_i     (issue),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    cu u_cu (
        .result      (cu_result),
        .instruction (fifo_head)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        opcode_d = opcode_q;
        err_d    = err_q;
        count_d  = count_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            if (handshake) count_d = count_q + OPS_ONE;
            if (issue && head_illegal) err_d = 1'b1;
            if (load) begin
                result_d = cu_result;
                opcode_d = fifo_head[OPC_MSB:OPC_LSB];
            end
            case (state_q)
                S_IDLE: begin
                    state_d = valid_next ? S_RUN : S_IDLE;
                end
                S_RUN, S_STALL: begin
                    if (!valid_next)              state_d = S_IDLE;
                    else if (!out_ready)          state_d = S_STALL;
                    else                          state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            opcode_q <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            opcode_q <= opcode_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// tb/tb_alu_issue_sequencer.sv - self-checking bench for alu_issue_sequencer
module tb_alu_issue_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [18:0]       in_instr;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_result;
    logic [2:0]        out_opcode;
    logic              busy;
    logic              err_illegal;
    logic [CNT_W-1:0]  op_count;

    alu_issue_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_opcode  (out_opcode),
        .busy        (busy),
        .err_illegal (err_illegal),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a queue of pending instructions plus the output register.
    logic [18:0]      mq[$];
    bit               m_ov;
    logic [7:0]       m_res;
    logic [2:0]       m_opc;
    bit               m_err;
    logic [CNT_W-1:0] m_cnt;

    typedef struct {
        logic [18:0] instr;
        logic [7:0]  exp_res;
        logic [2:0]  exp_opc;
    } vec_t;
    vec_t tbl [9];

    function automatic logic [18:0] mk(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b};
    endfunction

    function automatic logic [7:0] ref_alu(input logic [18:0] ins);
        int a, b;
        a = int'(ins[15:8]);
        b = int'(ins[7:0]);
        case (ins[18:16])
            3'd1: return 8'((a + b) % 256);
            3'd2: return 8'((a - b + 256) % 256);
            3'd3: return 8'((a + 1) % 256);
            3'd4: return 8'((a + 255) % 256);
            3'd5: return 8'(a & b);
            3'd6: return 8'(a | b);
            3'd7: return 8'(255 - a);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ov  = 0;
        m_res = '0;
        m_opc = '0;
        m_err = 0;
        m_cnt = '0;
    endtask

    task automatic model_edge(input bit iv, input logic [18:0] ins, input bit ordy, input bit fl);
        bit          can_push;
        bit          do_issue;
        logic [18:0] h;
        can_push = (mq.size() < DEPTH);
        if (fl) begin
            mq.delete();
            m_ov = 0;
            return;
        end
        do_issue = (mq.size() != 0) && (!m_ov || ordy);
        if (m_ov && ordy) begin
            m_cnt = m_cnt + 1'b1;
            m_ov  = 0;
        end
        if (do_issue) begin
            h = mq.pop_front();
            if (h[18:16] == 3'd0) begin
                m_err = 1;
            end else begin
                m_res = ref_alu(h);
                m_opc = h[18:16];
                m_ov  = 1;
            end
        end
        if (iv && can_push) mq.push_back(ins);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".in_ready"},    32'(in_ready),    32'(mq.size() < DEPTH));
        check({tag, ".out_valid"},   32'(out_valid),   32'(m_ov));
        check({tag, ".out_result"},  32'(out_result),  32'(m_res));
        check({tag, ".out_opcode"},  32'(out_opcode),  32'(m_opc));
        check({tag, ".busy"},        32'(busy),        32'((mq.size() != 0) || m_ov));
        check({tag, ".err_illegal"}, 32'(err_illegal), 32'(m_err));
        check({tag, ".op_count"},    32'(op_count),    32'(m_cnt));
    endtask

    // Drive one cycle of inputs, advance model and DUT by one edge, compare.
    task automatic step(input string tag, input bit iv, input logic [18:0] ins, input bit ordy, input bit fl);
        in_valid  = iv;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge(iv, ins, ordy, fl);
        #1;
        check_all(tag);
    endtask

    logic [7:0]       got[$];
    logic [CNT_W-1:0] base;
    int               n_acc;
    int               cyc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0; flush = 1'b0;
        model_reset();

        tbl[0] = '{mk(3'd1, 8'h23, 8'h14), 8'h37, 3'd1};
        tbl[1] = '{mk(3'd2, 8'h23, 8'h14), 8'h0F, 3'd2};
        tbl[2] = '{mk(3'd3, 8'h23, 8'h14), 8'h24, 3'd3};
        tbl[3] = '{mk(3'd4, 8'h23, 8'h14), 8'h22, 3'd4};
        tbl[4] = '{mk(3'd5, 8'h23, 8'h14), 8'h00, 3'd5};
        tbl[5] = '{mk(3'd6, 8'h23, 8'h14), 8'h37, 3'd6};
        tbl[6] = '{mk(3'd7, 8'h23, 8'h14), 8'hDC, 3'd7};
        tbl[7] = '{mk(3'd1, 8'hFF, 8'h01), 8'h00, 3'd1};
        tbl[8] = '{mk(3'd4, 8'h00, 8'h00), 8'hFF, 3'd4};

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.in_ready_const", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // Table: one push per cycle with out_ready high; result i shows one edge after push i.
        for (int i = 0; i < 9; i++) begin
            step("tbl", 1'b1, tbl[i].instr, 1'b1, 1'b0);
            if (i == 0) check("tbl.first_latency_valid", 32'(out_valid), 32'd0);
            if (i > 0) begin
                check($sformatf("tbl[%0d].valid", i - 1),  32'(out_valid),  32'd1);
                check($sformatf("tbl[%0d].result", i - 1), 32'(out_result), 32'(tbl[i-1].exp_res));
                check($sformatf("tbl[%0d].opcode", i - 1), 32'(out_opcode), 32'(tbl[i-1].exp_opc));
            end
            if (i == 2) check("tbl.op_count_first", 32'(op_count), 32'd1);
        end
        step("tbl_tail", 1'b0, '0, 1'b1, 1'b0);
        check("tbl[8].result", 32'(out_result), 32'(tbl[8].exp_res));
        check("tbl[8].opcode", 32'(out_opcode), 32'(tbl[8].exp_opc));
        step("tbl_drain", 1'b0, '0, 1'b1, 1'b0);
        check("tbl.op_count_all", 32'(op_count), 32'd9);

        // Back-pressure: 5 ADDs with out_ready low fill output register + FIFO.
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 5 && cyc < 20) begin
            if (mq.size() < DEPTH) begin
                step("bp_fill", 1'b1, mk(3'd1, 8'(n_acc + 1), 8'h10), 1'b0, 1'b0);
                n_acc++;
            end else begin
                step("bp_fill", 1'b0, '0, 1'b0, 1'b0);
            end
            cyc++;
        end
        check("bp.accepted", 32'(n_acc), 32'd5);
        check("bp.in_ready_full", 32'(in_ready), 32'd0);
        step("bp_hold", 1'b1, mk(3'd1, 8'h99, 8'h00), 1'b0, 1'b0);
        check("bp.result_stable", 32'(out_result), 32'h11);
        got.delete();
        for (int k = 0; k < 8; k++) begin
            if (out_valid) got.push_back(out_result);
            step("bp_drain", 1'b0, '0, 1'b1, 1'b0);
        end
        check("bp.n_results", 32'(got.size()), 32'd5);
        for (int k = 0; k < 5 && k < got.size(); k++)
            check($sformatf("bp.order[%0d]", k), 32'(got[k]), 32'(8'h11 + 8'(k)));

        // Illegal opcode between two ADDs.
        base = m_cnt;
        got.delete();
        step("ill", 1'b1, mk(3'd1, 8'h01, 8'h02), 1'b1, 1'b0);
        step("ill", 1'b1, mk(3'd0, 8'h55, 8'h66), 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            if (out_valid) got.push_back(out_result);
            step("ill", k == 0, mk(3'd1, 8'h03, 8'h04), 1'b1, 1'b0);
        end
        check("ill.n_results", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("ill.res0", 32'(got[0]), 32'h03);
            check("ill.res1", 32'(got[1]), 32'h07);
        end
        check("ill.err", 32'(err_illegal), 32'd1);
        check("ill.op_count", 32'(op_count), 32'(base + 2));
        step("ill_sticky", 1'b1, mk(3'd6, 8'h0F, 8'hF0), 1'b1, 1'b0);
        step("ill_sticky", 1'b0, '0, 1'b1, 1'b0);
        step("ill_sticky", 1'b0, '0, 1'b1, 1'b0);
        check("ill.err_sticky", 32'(err_illegal), 32'd1);

        // Flush with one result held and three buffered; push in the flush cycle is dropped.
        for (int k = 0; k < 4; k++) step("fl_fill", 1'b1, mk(3'd3, 8'(k), 8'h00), 1'b0, 1'b0);
        check("fl.pre_valid", 32'(out_valid), 32'd1);
        base = m_cnt;
        step("fl", 1'b1, mk(3'd1, 8'h40, 8'h40), 1'b1, 1'b1);
        check("fl.out_valid", 32'(out_valid), 32'd0);
        check("fl.busy", 32'(busy), 32'd0);
        check("fl.op_count", 32'(op_count), 32'(base));
        step("fl_after", 1'b0, '0, 1'b1, 1'b0);
        check("fl.after_valid", 32'(out_valid), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            step("rnd", 1'($urandom_range(0, 1)),
                 {3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end

        // Asynchronous reset in the middle of a stream.
        for (int k = 0; k < 3; k++) step("ar_fill", 1'b1, mk(3'd2, 8'h50, 8'(k)), 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar.out_valid",   32'(out_valid),   32'd0);
        check("ar.in_ready",    32'(in_ready),    32'd1);
        check("ar.busy",        32'(busy),        32'd0);
        check("ar.out_result",  32'(out_result),  32'd0);
        check("ar.out_opcode",  32'(out_opcode),  32'd0);
        check("ar.err_illegal", 32'(err_illegal), 32'd0);
        check("ar.op_count",    32'(op_count),    32'd0);
        model_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_all("ar_hold");
        rst_n = 1'b1;
        step("ar_post", 1'b1, mk(3'd5, 8'hF0, 8'h3C), 1'b1, 1'b0);
        step("ar_post", 1'b0, '0, 1'b1, 1'b0);
        check("ar.post_result", 32'(out_result), 32'h30);
        step("ar_post", 1'b0, '0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
